// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Shares one AXI4-lite read port (AR/R) of a memory slave between
//            two read masters (m0 = IFU, m1 = LSU load path). Only one read
//            is outstanding at a time. Grant is round-robin or fixed priority.
//            An optional response timeout answers the master with SLVERR and
//            later drains the slave's late beat.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            m_arvalid/m_arready     - per-master AR handshake (bit i = master i)
//            m_araddr/m_arsize       - {m1, m0} AR address / size
//            m_rvalid/m_rready       - per-master R handshake
//            m_rdata/m_rresp         - R data / response, broadcast
//            s_ar*/s_r*              - slave-side AR and R channels
//            grant                   - index of the owning master (debug)
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
   parameter int RR_EN   = 1,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  m_arvalid,
   output logic [1:0]  m_arready,
   input  logic [63:0] m_araddr,
   input  logic [5:0]  m_arsize,
   output logic [1:0]  m_rvalid,
   input  logic [1:0]  m_rready,
   output logic [31:0] m_rdata,
   output logic [1:0]  m_rresp,
   output logic        s_arvalid,
   input  logic        s_arready,
   output logic [31:0] s_araddr,
   output logic [2:0]  s_arsize,
   input  logic        s_rvalid,
   output logic        s_rready,
   input  logic [31:0] s_rdata,
   input  logic [1:0]  s_rresp,
   output logic        grant
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_ERR   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic [1:0]       c_RESP_OKAY   = 2'b00;
   localparam logic [1:0]       c_RESP_SLVERR = 2'b10;
   localparam bit               c_TO_EN       = (TIMEOUT != 0);
   // Counter value on the last empty DATA cycle before the timeout fires;
   // the increment on that cycle is what makes cnt reach TIMEOUT.
   localparam logic [CNT_W-1:0] c_TO_LAST     = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last;
   logic             r_grant;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_addr;
   logic [2:0]       r_size;

   logic             w_winner;
   logic             w_any_req;
   logic             w_ar_hs;
   logic             w_last_upd;
   logic             w_cnt_clr;
   logic             w_cnt_inc;

   // Winner selection: a sole requester always wins; on a tie round-robin
   // favours the master that did not complete last, fixed priority picks m0.
   always_comb begin
      w_any_req = |m_arvalid;
      if (m_arvalid == 2'b11) begin
         w_winner = (RR_EN != 0) ? ~r_last : 1'b0;
      end else begin
         w_winner = m_arvalid[1];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      m_arready   = 2'b00;
      m_rvalid    = 2'b00;
      m_rdata     = 32'd0;
      m_rresp     = c_RESP_OKAY;
      s_arvalid   = 1'b0;
      s_rready    = 1'b0;
      w_ar_hs     = 1'b0;
      w_last_upd  = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // The winner is by construction asserting arvalid, so its
            // ready doubles as the handshake.
            if (w_any_req) begin
               m_arready[w_winner] = 1'b1;
               w_ar_hs             = 1'b1;
               w_state_nxt         = S_ADDR;
            end
         end
         S_ADDR: begin
            s_arvalid = 1'b1;
            if (s_arready) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            m_rvalid[r_grant] = s_rvalid;
            s_rready          = m_rready[r_grant];
            m_rdata           = s_rdata;
            m_rresp           = s_rresp;
            if (s_rvalid && m_rready[r_grant]) begin
               w_last_upd  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (!s_rvalid) begin
               // A beat held by master backpressure never counts as waiting.
               w_cnt_inc = 1'b1;
               if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
                  w_state_nxt = S_ERR;
               end
            end
         end
         S_ERR: begin
            m_rvalid[r_grant] = 1'b1;
            m_rresp           = c_RESP_SLVERR;
            if (m_rready[r_grant]) begin
               w_last_upd  = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The slave still owes one beat; swallow it so it never
            // reaches a master.
            s_rready = 1'b1;
            if (s_rvalid) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_grant <= 1'b0;
         r_cnt   <= '0;
         r_addr  <= 32'd0;
         r_size  <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ar_hs) begin
            r_grant <= w_winner;
            r_addr  <= w_winner ? m_araddr[63:32] : m_araddr[31:0];
            r_size  <= w_winner ? m_arsize[5:3]   : m_arsize[2:0];
         end
         if (w_last_upd) begin
            r_last <= r_grant;
         end
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end
      end
   end

   assign s_araddr = r_addr;
   assign s_arsize = r_size;
   assign grant    = r_grant;

endmodule
`default_nettype wire
